// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory initiator: request op codes, memory
// MemWrite/MemRead codes, FSM states and small op-classification helpers.
package mem_access_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_LUI = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;
    localparam logic [3:0] OP_SH  = 4'd8;
    localparam logic [3:0] OP_SB  = 4'd9;

    localparam logic [1:0] MW_SW   = 2'b11;
    localparam logic [1:0] MW_SH   = 2'b10;
    localparam logic [1:0] MW_SB   = 2'b01;
    localparam logic [1:0] MW_NONE = 2'b00;

    localparam logic [2:0] MR_LW   = 3'b110;
    localparam logic [2:0] MR_LH   = 3'b010;
    localparam logic [2:0] MR_LB   = 3'b100;
    localparam logic [2:0] MR_LUI  = 3'b111;
    localparam logic [2:0] MR_NONE = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_SB);
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_LUI);
    endfunction

    function automatic logic [1:0] mw_code(input logic [3:0] op);
        case (op)
            OP_SW:   return MW_SW;
            OP_SH:   return MW_SH;
            OP_SB:   return MW_SB;
            default: return MW_NONE;
        endcase
    endfunction

    // Unsigned variants share the signed read code; the memory always returns zero-extended data.
    function automatic logic [2:0] mr_code(input logic [3:0] op);
        case (op)
            OP_LW:         return MR_LW;
            OP_LH, OP_LHU: return MR_LH;
            OP_LB, OP_LBU: return MR_LB;
            OP_LUI:        return MR_LUI;
            default:       return MR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: maps a load op and the memory's zero-extended read word to the
// architectural load result. Buses are [0:31], bit 0 is the MSB.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [0:31] mem_data,
    output logic [0:31] rdata
);

    // Select the extension rule for the latched load op.
    always_comb begin
        rdata = 32'h0000_0000;
        case (op)
            OP_LW:   rdata = mem_data;
            OP_LH:   rdata = {{16{mem_data[16]}}, mem_data[16:31]};
            OP_LHU:  rdata = {16'h0000, mem_data[16:31]};
            OP_LB:   rdata = {{24{mem_data[24]}}, mem_data[24:31]};
            OP_LBU:  rdata = {24'h00_0000, mem_data[24:31]};
            OP_LUI:  rdata = {mem_data[0:15], 16'h0000};
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store initiator for the data memory.
// Optional macro MISALIGN_CHECK_EN faults misaligned word/halfword accesses.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [0:31]       req_wdata,
    output logic              resp_valid,
    output logic [0:31]       resp_rdata,
    output logic              resp_fault,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [0:31]       mem_writedata,
    output logic [1:0]        mem_MemWrite,
    output logic [2:0]        mem_MemRead,
    input  logic [0:31]       mem_data
);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          op_q, op_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [0:31]         resp_rdata_q, resp_rdata_d;
    logic                resp_fault_q, resp_fault_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [0:31]         mem_writedata_q, mem_writedata_d;
    logic [1:0]          mw_q, mw_d;
    logic [2:0]          mr_q, mr_d;
    logic [0:31]         ext_s;
    logic                misaligned_s;

    load_extend u_load_extend (
        .op       (op_q),
        .mem_data (mem_data),
        .rdata    (ext_s)
    );

`ifdef MISALIGN_CHECK_EN
    // Alignment rule per access size, evaluated on the incoming request.
    always_comb begin
        misaligned_s = 1'b0;
        case (req_op)
            OP_SW, OP_LW, OP_LUI: misaligned_s = (req_addr[1:0] != 2'b00);
            OP_SH, OP_LH, OP_LHU: misaligned_s = req_addr[0];
            default:              misaligned_s = 1'b0;
        endcase
    end
`else
    assign misaligned_s = 1'b0;
`endif

    // Next-state and next-output computation for the access FSM.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        op_d            = op_q;
        req_ready_d     = req_ready_q;
        resp_valid_d    = 1'b0;
        resp_rdata_d    = 32'h0000_0000;
        resp_fault_d    = 1'b0;
        busy_d          = busy_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        mw_d            = mw_q;
        mr_d            = mr_q;
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                mw_d        = MW_NONE;
                mr_d        = MR_NONE;
                if (!req_valid || (req_op == OP_NOP)) begin
                    state_d = S_IDLE;
                end else if (!op_is_legal(req_op) || misaligned_s) begin
                    // Rejected requests answer straight away without touching memory.
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b1;
                    req_ready_d  = 1'b0;
                    busy_d       = 1'b1;
                end else begin
                    state_d         = S_ISSUE;
                    op_d            = req_op;
                    mem_address_d   = req_addr;
                    mem_writedata_d = req_wdata;
                    mw_d            = mw_code(req_op);
                    mr_d            = mr_code(req_op);
                    req_ready_d     = 1'b0;
                    busy_d          = 1'b1;
                end
            end
            S_ISSUE: begin
                if (op_is_load(op_q)) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(MEM_LATENCY - 1);
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    mw_d         = MW_NONE;
                    mr_d         = MR_NONE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ext_s;
                    mw_d         = MW_NONE;
                    mr_d         = MR_NONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                mw_d        = MW_NONE;
                mr_d        = MR_NONE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= 4'd0;
            op_q            <= OP_NOP;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'h0000_0000;
            resp_fault_q    <= 1'b0;
            busy_q          <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= 32'h0000_0000;
            mw_q            <= MW_NONE;
            mr_q            <= MR_NONE;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            op_q            <= op_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_fault_q    <= resp_fault_d;
            busy_q          <= busy_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            mw_q            <= mw_d;
            mr_q            <= mr_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_fault    = resp_fault_q;
    assign busy          = busy_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign mem_MemWrite  = mw_q;
    assign mem_MemRead   = mr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed big-endian memory model plus a
// reference byte array; MISALIGN_CHECK_EN enables the misalignment steps.
module tb_mem_access_unit;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_fault, busy;
    logic [31:0] resp_rdata, mem_address, mem_writedata, mem_data;
    logic [1:0]  mem_MemWrite;
    logic [2:0]  mem_MemRead;

    int compared = 0;
    int mismatched = 0;
    int rd_age = 0;
    logic [7:0]  mem     [0:255] = '{default: 8'h00};
    logic [7:0]  ref_mem [0:255] = '{default: 8'h00};
    logic [7:0]  ra;
    logic [31:0] word;

    mem_access_unit #(.MEM_LATENCY(LAT), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .busy(busy), .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // Memory model: writes at negedge, read data valid LAT posedges after MemRead rises.
    always @(negedge clk) begin
        case (mem_MemWrite)
            2'b11: begin
                mem[mem_address[7:0]]         <= mem_writedata[31:24];
                mem[mem_address[7:0] + 8'd1]  <= mem_writedata[23:16];
                mem[mem_address[7:0] + 8'd2]  <= mem_writedata[15:8];
                mem[mem_address[7:0] + 8'd3]  <= mem_writedata[7:0];
            end
            2'b10: begin
                mem[mem_address[7:0] + 8'd2]  <= mem_writedata[15:8];
                mem[mem_address[7:0] + 8'd3]  <= mem_writedata[7:0];
            end
            2'b01: mem[mem_address[7:0] + 8'd3] <= mem_writedata[7:0];
            default: ;
        endcase
    end

    always @(posedge clk) rd_age <= (mem_MemRead == 3'b000) ? 0 : rd_age + 1;

    always_comb begin
        ra   = mem_address[7:0];
        word = {mem[ra], mem[ra + 8'd1], mem[ra + 8'd2], mem[ra + 8'd3]};
        if (rd_age < LAT) mem_data = 32'hA5A5_5A5A;
        else begin
            case (mem_MemRead)
                3'b110, 3'b111: mem_data = word;
                3'b010:         mem_data = {16'h0000, word[15:0]};
                3'b100:         mem_data = {24'h000000, word[7:0]};
                default:        mem_data = 32'h0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_misaligned(input logic [3:0] op, input logic [31:0] a);
`ifdef MISALIGN_CHECK_EN
        if (op == 4'd1 || op == 4'd6 || op == 4'd7) return a[1:0] != 2'b00;
        if (op == 4'd2 || op == 4'd3 || op == 4'd8) return a[0];
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {ref_mem[b], ref_mem[b + 8'd1], ref_mem[b + 8'd2], ref_mem[b + 8'd3]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a);
        logic [31:0] w;
        w = ref_word(a);
        case (op)
            4'd1:    return w;
            4'd2:    return 32'(int'($signed(w[15:0])));
            4'd3:    return w & 32'h0000_FFFF;
            4'd4:    return 32'(int'($signed(w[7:0])));
            4'd5:    return w & 32'h0000_00FF;
            4'd6:    return w & 32'hFFFF_0000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk_mem(input string tag);
        int bad = -1;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i] && bad < 0) bad = i;
        chk(tag, (bad < 0) ? 32'h0 : {24'h0, mem[bad]}, (bad < 0) ? 32'h0 : {24'h0, ref_mem[bad]});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        chk({tag, "_rvalid"}, {31'h0, resp_valid}, 32'h0);
        chk({tag, "_fault"}, {31'h0, resp_fault}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_rdata"}, resp_rdata, 32'h0);
        chk({tag, "_mctl"}, {27'h0, mem_MemWrite, mem_MemRead}, 32'h0);
        chk({tag, "_maddr"}, mem_address, 32'h0);
        chk({tag, "_mwdata"}, mem_writedata, 32'h0);
    endtask

    // One complete request with expectations from the reference model.
    task automatic do_req(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] wd);
        int lat_exp = 1, mw_exp = 0, mr_exp = 0, got = -1, mw_n = 0, mr_n = 0, both = 0;
        logic fault_exp = 1'b1, f_obs = 1'b0, busy_bad = 1'b0;
        logic [31:0] rd_exp = 32'h0, rd_obs = 32'h0;
        if (op <= 4'd9 && !is_misaligned(op, a)) begin
            fault_exp = 1'b0;
            if (op >= 4'd1 && op <= 4'd6) begin
                lat_exp = LAT + 2; mr_exp = LAT + 1; rd_exp = ref_load(op, a);
            end else begin
                lat_exp = 2; mw_exp = 1;
                if (op == 4'd7) begin
                    ref_mem[a[7:0]] = wd[31:24]; ref_mem[a[7:0] + 8'd1] = wd[23:16];
                end
                if (op != 4'd9) ref_mem[a[7:0] + 8'd2] = wd[15:8];
                ref_mem[a[7:0] + 8'd3] = wd[7:0];
            end
        end
        @(negedge clk);
        chk({tag, "_ready_before"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (mem_MemWrite != 2'b00) mw_n++;
            if (mem_MemRead != 3'b000) mr_n++;
            if (mem_MemWrite != 2'b00 && mem_MemRead != 3'b000) both++;
            if (!busy) busy_bad = 1'b1;
            if (resp_valid) begin
                got = c; rd_obs = resp_rdata; f_obs = resp_fault;
                break;
            end
        end
        req_valid = 1'b0;
        if (got < 0) chk({tag, "_timeout"}, 32'h0, 32'h1);
        chk({tag, "_latency"}, 32'(got), 32'(lat_exp));
        chk({tag, "_fault"}, {31'h0, f_obs}, {31'h0, fault_exp});
        chk({tag, "_rdata"}, rd_obs, rd_exp);
        chk({tag, "_mw_cycles"}, 32'(mw_n), 32'(mw_exp));
        chk({tag, "_mr_cycles"}, 32'(mr_n), 32'(mr_exp));
        chk({tag, "_overlap"}, 32'(both), 32'h0);
        chk({tag, "_busy"}, {31'h0, busy_bad}, 32'h0);
        @(negedge clk);
        chk({tag, "_after"}, {29'h0, resp_valid, req_ready, busy}, 32'h2);
        chk_mem({tag, "_mem"});
    endtask

    initial begin
        logic seen;
        logic [3:0] op;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        do_req("sw10", 4'd7, 32'h10, 32'hDEAD_BEEF);
        chk("sw10_bytes", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hDEAD_BEEF);
        do_req("lw10", 4'd1, 32'h10, 32'h0);
        do_req("lb10", 4'd4, 32'h10, 32'h0);
        do_req("lbu10", 4'd5, 32'h10, 32'h0);
        do_req("lh10", 4'd2, 32'h10, 32'h0);
        do_req("lhu10", 4'd3, 32'h10, 32'h0);
        do_req("lui10", 4'd6, 32'h10, 32'h0);
        do_req("sb20", 4'd9, 32'h20, 32'h1234_5678);
        chk("sb20_bytes", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'h0000_0078);
        do_req("sh30", 4'd8, 32'h30, 32'hCAFE_8001);
        do_req("lh30", 4'd2, 32'h30, 32'h0);

        // Reset during the WAIT cycle of a load.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd1; req_addr = 32'h10;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        chk("rst_wait_mr", {29'h0, mem_MemRead}, 32'h6);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_mid");
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
        chk("rst_mid_noresp", {31'h0, seen}, 32'h0);
        do_req("lw_after_rst", 4'd1, 32'h10, 32'h0);

        do_req("illegal12", 4'd12, 32'h10, 32'hFFFF_FFFF);
        do_req("illegal15", 4'd15, 32'h40, 32'h0);

        // NOP is consumed silently.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd0;
        @(negedge clk); req_valid = 1'b0;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (resp_valid || busy || !req_ready) seen = 1'b1; end
        chk("nop_silent", {31'h0, seen}, 32'h0);

`ifdef MISALIGN_CHECK_EN
        do_req("mis_lw11", 4'd1, 32'h11, 32'h0);
        do_req("mis_sh21", 4'd8, 32'h21, 32'hFFFF_FFFF);
        do_req("ok_lb11", 4'd4, 32'h11, 32'h0);
`endif

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 12));
            do_req($sformatf("rnd%0d", i), op, {22'h0, 8'($urandom_range(0, 63)), 2'b00}, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory port.
- Accepts one load/store request at a time from the MEM pipeline stage and drives the memory's address, writedata, MemWrite and MemRead lines using the memory's fixed encodings.
- Captures read data after the memory's read edge, applies sign or zero extension, and returns a single-cycle response.
- Holds the pipeline stalled (via `busy`) while an access is in flight.

Parameters:
- MEM_LATENCY, 1: posedges between driving MemRead and mem_data being valid; legal range 1..15.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_op  in  4  0=NOP, 1=LW, 2=LH, 3=LHU, 4=LB, 5=LBU, 6=LUI, 7=SW, 8=SH, 9=SB; 10-15 illegal.
- req_addr  in  ADDR_W  word-base byte address.
- req_wdata  in  32  store data; sh uses bits 16:31, sb uses bits 24:31.
- resp_valid  out  1  one-cycle pulse: load data valid or store complete.
- resp_rdata  out  32  extended load result; 0 for stores.
- resp_fault  out  1  qualifies resp_valid; access was not performed.
- busy  out  1  high from accept until the cycle of resp_valid inclusive.
- mem_address  out  ADDR_W  to memory address.
- mem_writedata  out  32  to memory writedata.
- mem_MemWrite  out  2  11=sw, 10=sh, 01=sb, 00=idle.
- mem_MemRead  out  3  110=lw, 010=lh, 100=lb, 111=lui, 000=idle.
- mem_data  in  32  from memory data.
- All 32-bit buses are declared [0:31], with bit 0 as the MSB, to match the memory port.

Behaviour:
- Reset values: all outputs 0, except req_ready=1. State=IDLE, latency counter=0. Reset mid-access aborts it immediately; no response is generated. The memory may still complete a write at the following negedge; that is accepted.
- State machine:
  - IDLE: req_ready=1. When req_valid=1 and req_op is neither NOP nor illegal, latch op, addr and wdata and go to ISSUE. NOP is consumed with no response. An illegal op produces resp_valid=1 and resp_fault=1 in the next cycle, then returns to IDLE.
  - ISSUE (1 cycle): drive mem_address, mem_writedata and the encoded MemWrite/MemRead.
    - Store: the memory writes at the negedge inside this cycle. Go to RESP.
    - Load: go to WAIT with counter=MEM_LATENCY-1. MemRead is held through WAIT.
  - WAIT: decrement the counter each cycle. When it reaches 0, sample mem_data and go to RESP. With MEM_LATENCY=1, WAIT lasts 1 cycle.
  - RESP: resp_valid=1 for one cycle. Mem controls return to 00/000. Return to IDLE. req_ready is 0 here, so back-to-back requests incur one idle cycle.
- Latency from accept to resp_valid: store 2 cycles; load MEM_LATENCY+2 cycles.
- Mem controls are nonzero only in ISSUE and WAIT. MemWrite and MemRead are never nonzero simultaneously.
- Extension, with the memory returning zero-extended data:
  - LB: sign-extend bit 24.
  - LBU: zero-extend bits 24:31.
  - LH: sign-extend bit 16.
  - LHU: zero-extend bits 16:31.
  - LW: pass through.
  - LUI: bits 0:15 from mem_data, bits 16:31 = 0.
- An input change of req_* while busy is ignored.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined: SW/LW/LUI require addr[1:0]=00; SH/LH/LHU require addr[0]=0. A violating request skips ISSUE, drives no mem controls, and gives resp_valid=1 with resp_fault=1 one cycle after accept.
- Undefined: addresses pass through unchecked; resp_fault is raised only for illegal ops.

Decomposition:
- Package mem_access_pkg holds:
  - op codes (OP_LW … OP_SB);
  - MemWrite codes (MW_SW=2'b11, MW_SH=2'b10, MW_SB=2'b01, MW_NONE);
  - MemRead codes (MR_LW=3'b110, MR_LH=3'b010, MR_LB=3'b100, MR_LUI=3'b111, MR_NONE);
  - state enum.
- One combinational sub-module, load_extend, maps (op, mem_data) to resp_rdata.

Test Plan:
- After reset: req_ready=1 and all mem controls 0. Issue SW addr=0x10, wdata=0xDEADBEEF → MemWrite=11 for exactly 1 cycle, resp_valid 2 cycles after accept, memory bytes 0x10..0x13 = DE AD BE EF.
- LW 0x10 after the above → MemRead=110 held MEM_LATENCY+1 cycles, resp_rdata=0xDEADBEEF at accept+3.
- Memory byte at 0x13=0xEF: LB 0x10 → 0xFFFFFFEF; LBU → 0x000000EF. Memory bytes at 0x12/0x13=0xBE/0xEF: LH → 0xFFFFBEEF; LHU → 0x0000BEEF.
- LUI 0x10 → 0xDEAD0000. SB 0x20, wdata=0x12345678 → only memory byte 0x23 = 0x78.
- Assert reset during WAIT of an LW → no resp_valid, next cycle all outputs at reset values, a following LW completes normally.
- req_op=12 → resp_fault=1 and no mem activity. With MISALIGN_CHECK_EN defined, LW 0x11 → resp_fault=1 with MemRead staying 000.
